// File: rtl/snoop_pkg.sv
// Shared definitions for the MSI snooping bus: arbiter states,
// default sizes and bus message field positions.
package snoop_pkg;

   localparam int N_REQ_DEF   = 3;
   localparam int BUS_W_DEF   = 9;
   localparam int TIMEOUT_DEF = 15;

   // Bus message layout: op in [8:7], tag/address in [6:0]
   localparam int OP_MSB  = 8;
   localparam int OP_LSB  = 7;
   localparam int TAG_MSB = 6;
   localparam int TAG_LSB = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BCAST,
      S_SNOOP,
      S_FLUSH_WAIT,
      S_MEM_WAIT,
      S_DONE
   } state_t;

   function automatic logic is_wait(input state_t s);
      return (s == S_FLUSH_WAIT) || (s == S_MEM_WAIT);
   endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_picker.sv
// Round-robin requester select: first set req bit scanning
// upward from last_winner+1, wrapping modulo N_REQ.
module rr_picker
   import snoop_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_last,
   output logic [N_REQ-1:0] o_win,
   output logic [IDX_W-1:0] o_win_idx,
   output logic             o_any
);

   // Scan offsets 1..N_REQ so the last winner is checked last
   always_comb begin
      logic             found;
      int               idx;
      logic [IDX_W-1:0] idx_v;
      o_win     = '0;
      o_win_idx = '0;
      o_any     = |i_req;
      found     = 1'b0;
      idx       = 0;
      idx_v     = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = int'(i_last) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         idx_v = IDX_W'(idx);
         if (!found && i_req[idx_v]) begin
            found        = 1'b1;
            o_win[idx_v] = 1'b1;
            o_win_idx    = idx_v;
         end
      end
   end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping bus arbiter: round-robin grant, broadcast, snoop, memory wait.
// Optional macro ARB_TIMEOUT_EN adds a wait-state timeout with err pulse.
module snoop_bus_arbiter
   import snoop_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int BUS_W   = BUS_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic [N_REQ-1:0]       i_req,
   input  logic [N_REQ*BUS_W-1:0] i_msg_in,
   input  logic [N_REQ-1:0]       i_flush,
   input  logic                   i_mem_ack,
   output logic [N_REQ-1:0]       o_grant,
   output logic [BUS_W-1:0]       o_bus_out,
   output logic                   o_bus_valid,
   output logic                   o_snoop_phase,
   output logic [N_REQ-1:0]       o_done,
   output logic                   o_busy,
   output logic                   o_err
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           r_state;
   state_t           w_next;
   logic [N_REQ-1:0] r_grant;
   logic [N_REQ-1:0] w_win;
   logic [N_REQ-1:0] w_flush_m;
   logic [IDX_W-1:0] r_win_idx;
   logic [IDX_W-1:0] r_last;
   logic [IDX_W-1:0] w_win_idx;
   logic [BUS_W-1:0] r_bus;
   logic             w_any;
   logic             w_tmo;

   rr_picker #(
      .N_REQ (N_REQ)
   ) u_pick (
      .i_req     (i_req),
      .i_last    (r_last),
      .o_win     (w_win),
      .o_win_idx (w_win_idx),
      .o_any     (w_any)
   );

   // The owner's own flush bit is meaningless and is dropped
   assign w_flush_m = i_flush & ~r_grant;

   // State register
   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:       if (w_any) w_next = S_BCAST;
         S_BCAST:      w_next = S_SNOOP;
         S_SNOOP:      w_next = (|w_flush_m) ? S_FLUSH_WAIT
                                             : S_MEM_WAIT;
         S_FLUSH_WAIT: begin
            if (i_mem_ack)  w_next = S_MEM_WAIT;
            else if (w_tmo) w_next = S_DONE;
         end
         S_MEM_WAIT:   if (i_mem_ack || w_tmo) w_next = S_DONE;
         S_DONE:       w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   // Grant, latched message and round-robin history
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_grant   <= '0;
         r_bus     <= '0;
         r_win_idx <= '0;
         r_last    <= IDX_W'(N_REQ - 1);
      end else if (r_state == S_IDLE && w_any) begin
         r_grant   <= w_win;
         r_win_idx <= w_win_idx;
         r_bus     <= i_msg_in[w_win_idx*BUS_W +: BUS_W];
      end else if (r_state == S_DONE) begin
         r_grant <= '0;
         r_last  <= r_win_idx;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_err;

   assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1)) && !i_mem_ack;

   // Wait counter, cleared whenever the state changes
   always_ff @(posedge i_clock) begin
      if (i_reset)                r_cnt <= '0;
      else if (w_next != r_state) r_cnt <= '0;
      else if (is_wait(r_state))  r_cnt <= r_cnt + 1'b1;
   end

   // Error flag lines up with the DONE cycle it forces
   always_ff @(posedge i_clock) begin
      if (i_reset) r_err <= 1'b0;
      else         r_err <= is_wait(r_state) && w_tmo;
   end

   assign o_err = r_err;
`else
   logic w_unused_tmo;

   assign w_unused_tmo = (TIMEOUT > 0);
   assign w_tmo        = 1'b0;
   assign o_err        = 1'b0;
`endif

   assign o_grant       = r_grant;
   assign o_bus_out     = r_bus;
   assign o_bus_valid   = (r_state == S_BCAST);
   assign o_snoop_phase = (r_state == S_SNOOP);
   assign o_done        = (r_state == S_DONE) ? r_grant : '0;
   assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: arbitration order, latency,
// flush path, ignored acks, mid-transaction reset, wait-state hold.
module tb_snoop_bus_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req;
   logic [26:0] msg;
   logic [2:0]  flush;
   logic        ack;
   logic [2:0]  grant;
   logic [8:0]  bus_out;
   logic        bus_valid;
   logic        snoop;
   logic [2:0]  done;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;

   localparam logic [8:0] M0 = 9'h011;
   localparam logic [8:0] M1 = 9'h1A5;
   localparam logic [8:0] M2 = 9'h0F0;

   snoop_bus_arbiter dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_req         (req),
      .i_msg_in      (msg),
      .i_flush       (flush),
      .i_mem_ack     (ack),
      .o_grant       (grant),
      .o_bus_out     (bus_out),
      .o_bus_valid   (bus_valid),
      .o_snoop_phase (snoop),
      .o_done        (done),
      .o_busy        (busy),
      .o_err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transaction from IDLE; req dropped and msg scrambled after grant
   task automatic txn(input logic [2:0] rq, input logic [2:0] fl,
                      input logic [2:0] eg, input logic [8:0] eb);
      logic [26:0] saved;
      req = rq;
      tick;
      chk("grant", grant, eg);
      chk("bus_out", bus_out, eb);
      chk("bus_valid", bus_valid, 1);
      chk("snoop_in_bcast", snoop, 0);
      req   = 3'b000;
      saved = msg;
      msg   = ~msg;
      tick;
      chk("snoop", snoop, 1);
      chk("bus_valid_once", bus_valid, 0);
      chk("bus_latched", bus_out, eb);
      flush = fl;
      tick;
      flush = 3'b000;
      if ((fl & ~eg) != 3'b000) begin
         chk("flush_wait_busy", busy, 1);
         chk("flush_wait_nodone", done, 0);
         ack = 1'b1;
         tick;
         ack = 1'b0;
      end
      chk("wait_busy", busy, 1);
      chk("wait_nodone", done, 0);
      ack = 1'b1;
      tick;
      ack = 1'b0;
      chk("done", done, eg);
      chk("err", err, 0);
      tick;
      chk("idle_done", done, 0);
      chk("idle_grant", grant, 0);
      chk("idle_busy", busy, 0);
      msg = saved;
   endtask

   initial begin
      rst   = 1'b1;
      req   = 3'b000;
      msg   = {M2, M1, M0};
      flush = 3'b000;
      ack   = 1'b0;
      tick;
      tick;
      rst = 1'b0;
      chk("rst_grant", grant, 0);
      chk("rst_bus_out", bus_out, 0);
      chk("rst_bus_valid", bus_valid, 0);
      chk("rst_snoop", snoop, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);

      // Round-robin from requester 0
      txn(3'b111, 3'b000, 3'b001, M0);
      txn(3'b111, 3'b000, 3'b010, M1);
      txn(3'b111, 3'b000, 3'b100, M2);

      // Foreign flush takes the writeback path; own bit does not
      txn(3'b001, 3'b100, 3'b001, M0);
      txn(3'b001, 3'b001, 3'b001, M0);

      // Single requester 1, minimum latency
      txn(3'b010, 3'b000, 3'b010, M1);

      // mem_ack in IDLE/BCAST/SNOOP is ignored
      ack = 1'b1;
      req = 3'b100;
      tick;
      chk("ign_grant", grant, 3'b100);
      req = 3'b000;
      tick;
      chk("ign_snoop", snoop, 1);
      tick;
      ack = 1'b0;
      chk("ign_busy0", busy, 1);
      chk("ign_done0", done, 0);
      tick;
      chk("ign_busy1", busy, 1);
      chk("ign_done1", done, 0);
      ack = 1'b1;
      tick;
      ack = 1'b0;
      chk("ign_done", done, 3'b100);
      tick;
      chk("ign_idle", busy, 0);

      // Reset in MEM_WAIT clears everything and restores priority
      txn(3'b001, 3'b000, 3'b001, M0);
      req = 3'b001;
      tick;
      req = 3'b000;
      tick;
      tick;
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      tick;
      chk("post_rst_done", done, 0);
      txn(3'b011, 3'b000, 3'b001, M0);

      // Long memory wait
      req = 3'b010;
      tick;
      chk("wait_grant", grant, 3'b010);
      req = 3'b000;
      tick;
      tick;
`ifdef ARB_TIMEOUT_EN
      repeat (14) tick;
      chk("tmo_pre_busy", busy, 1);
      chk("tmo_pre_done", done, 0);
      tick;
      chk("tmo_done", done, 3'b010);
      chk("tmo_err", err, 1);
      tick;
      chk("tmo_idle", busy, 0);
      chk("tmo_err_clr", err, 0);
`else
      repeat (15) tick;
      chk("hold_busy", busy, 1);
      chk("hold_err", err, 0);
      chk("hold_done", done, 0);
      ack = 1'b1;
      tick;
      ack = 1'b0;
      chk("hold_done_late", done, 3'b010);
      tick;
      chk("hold_idle", busy, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
